pwm_profile_sequencer: RTL and testbench
========================================

Name: pwm_profile_sequencer

Overview:
Parametrised multi-state PWM profile engine and next generation of the fixed state-to-duty lookup. It walks a programmable N-state profile table, dwelling a fixed number of PWM periods per state. Each state either steps duty to its target or ramps toward it. It generates the PWM waveform itself and drives the motor/LED driver stage directly.

Parameters:
N_STATES, 6, number of profile entries; state index wraps N_STATES-1 -> 0
DUTY_W, 12, width of duty, target and PWM counter
PWM_PERIOD, 1200, clocks per PWM period; duty >= PWM_PERIOD means output constantly high
DWELL_PERIODS, 1000, PWM periods spent in each state (>= 1)
RAMP_STEP, 4, duty change per period in ramp mode (>= 1)
IDX_W, $clog2(N_STATES), state/config index width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  run enable; low = idle/restart
cfg_we  in  1  profile table write strobe
cfg_idx  in  IDX_W  table entry to write
cfg_target  in  DUTY_W  target duty for entry
cfg_ramp  in  1  1 = ramp mode, 0 = step mode
pwm_out  out  1  PWM waveform
duty  out  DUTY_W  duty currently applied
state  out  IDX_W  current profile state
period_tick  out  1  high in the last cycle of each PWM period
state_done  out  1  high in the tick cycle that advances state

Behaviour:
- Reset (rst=1 at a clk edge): pwm_cnt=0, dwell_cnt=0, state=0, duty=0; pwm_out=0, period_tick=0, state_done=0.
- Reset loads the default table: {0 step, 0 step, PWM_PERIOD ramp, PWM_PERIOD step, PWM_PERIOD step, 0 ramp}. Entries beyond 5 load 0 step; N_STATES < 6 truncates the list.
- en=0: pwm_cnt, dwell_cnt, state and duty are held at 0; pwm_out=0; ticks stay low. The table is retained and remains writable. When en rises, the profile restarts at state 0, period start.
- pwm_cnt counts 0..PWM_PERIOD-1 and wraps. period_tick = en && pwm_cnt==PWM_PERIOD-1 (combinational from registers).
- pwm_out = en && (pwm_cnt < duty), combinational. duty=0 gives always low. duty >= PWM_PERIOD gives always high.
- On each tick edge, state and dwell update first:
  - If dwell_cnt==DWELL_PERIODS-1: state advances (N_STATES-1 wraps to 0), dwell_cnt becomes 0, and state_done is high in that tick cycle.
  - Otherwise dwell_cnt increments.
- On the same tick edge, duty updates from the entry of the *new* state:
  - Step mode: duty = target.
  - Ramp mode: duty moves toward target by RAMP_STEP and saturates exactly at target, with no overshoot. The arithmetic is DUTY_W+1 wide, so there is no wrap below 0 or above 2^DUTY_W-1.
- Duty therefore changes only at period boundaries (glitch-free). A ramp that has not reached its target when the state ends continues from its current value; there is no jump.
- Table write: registered on the clk edge with cfg_we=1.
  - cfg_idx >= N_STATES: write ignored.
  - A write coincident with a tick edge is not seen by that tick's duty computation; it is seen from the next tick.
  - Writing the current state's entry affects duty only from the next tick.
- rst mid-period or mid-ramp: everything returns immediately to reset values, including the default table.

Decomposition:
- Package pwm_pkg:
  - typedef enum logic {PWM_STEP, PWM_RAMP} pwm_mode_t
  - struct pwm_entry_t {target, mode}
  - default profile constant array and function for entries beyond 5
- Sub-module pwm_duty_stepper: combinational next-duty from {cur, target, mode, RAMP_STEP}, holding the saturation arithmetic. Unit-testable alone.
- Top keeps counters, state register and table.

Test Plan:
- Default profile, PWM_PERIOD=10, DWELL_PERIODS=2, RAMP_STEP=3, default table with targets of 10 → per-period duty by state: s0 0,0; s1 0,0; s2 3,6; s3 10,10; s4 10,10; s5 7,4; then s0 0. state_done pulses every 20 clocks. pwm_out high for exactly duty clocks per period.
- Saturation: same params, RAMP_STEP=4, entry2 ramp to 10 with DWELL=4 → duty 4,8,10,10. Ramp down from 10 to 0 → 6,2,0,0. Never underflows.
- en drop at state 3, mid-period → pwm_out=0 and duty=0 on the next cycle. Re-enable → state=0, pwm_cnt=0, and the full sequence repeats as in scenario 1.
- Config write cfg_idx=1, target 5, step, landing on a tick edge that enters state 1 → that period duty=0, next period duty=5. A write with cfg_idx=7 (N_STATES=6) changes nothing.
- Boundaries: target=PWM_PERIOD → pwm_out constantly high across the wrap. Target 0 → constantly low. Target 4095 → constantly high with no wrap.
- rst asserted during the state 2 ramp after reprogramming entry 2 → outputs zero the next cycle. After release, entry 2 reverts to the default (PWM_PERIOD, ramp).

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and the power-on profile for the PWM profile sequencer.
// The default table is expressed relative to the PWM period so it scales with it.
package pwm_pkg;

    typedef enum logic {
        PWM_STEP = 1'b0,
        PWM_RAMP = 1'b1
    } pwm_mode_t;

    localparam int unsigned PWM_TGT_W     = 32;
    localparam int unsigned PWM_N_DEFAULT = 6;

    typedef struct packed {
        logic [PWM_TGT_W-1:0] target;
        pwm_mode_t            mode;
    } pwm_entry_t;

    // Bit i describes default entry i: full-scale target, and ramp mode.
    localparam logic [PWM_N_DEFAULT-1:0] DEF_FULL = 6'b011100;
    localparam logic [PWM_N_DEFAULT-1:0] DEF_RAMP = 6'b100100;

    function automatic pwm_entry_t default_entry(input int unsigned idx,
                                                 input int unsigned full_scale);
        pwm_entry_t e;
        e.target = '0;
        e.mode   = PWM_STEP;
        if (idx < PWM_N_DEFAULT) begin
            if (DEF_FULL[idx[2:0]]) e.target = PWM_TGT_W'(full_scale);
            if (DEF_RAMP[idx[2:0]]) e.mode   = PWM_RAMP;
        end
        return e;
    endfunction

endpackage

// File: rtl/pwm_duty_stepper.sv
// Next-duty calculation for one PWM period boundary: step straight to target,
// or ramp toward it by a fixed step and land exactly on it.
module pwm_duty_stepper
    import pwm_pkg::*;
#(
    parameter int unsigned DUTY_W    = 12,
    parameter int unsigned RAMP_STEP = 4
) (
    input  logic [DUTY_W-1:0] cur_duty,
    input  logic [DUTY_W-1:0] target_duty,
    input  pwm_mode_t         mode,
    output logic [DUTY_W-1:0] next_duty
);

    // Any step wider than the full duty range behaves like a step to target.
    localparam int unsigned     STEP_CAP = 32'd1 << DUTY_W;
    localparam logic [DUTY_W:0] STEP     =
        (DUTY_W+1)'((RAMP_STEP > STEP_CAP) ? STEP_CAP : RAMP_STEP);

    logic [DUTY_W:0] cur_w;
    logic [DUTY_W:0] tgt_w;
    logic [DUTY_W:0] up_sum;
    logic [DUTY_W:0] down_gap;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        cur_w     = {1'b0, cur_duty};
        tgt_w     = {1'b0, target_duty};
        up_sum    = cur_w + STEP;
        down_gap  = cur_w - tgt_w;
        next_duty = cur_duty;
        if (mode == PWM_STEP) begin
            next_duty = target_duty;
        end else if (cur_w < tgt_w) begin
            next_duty = (up_sum >= tgt_w) ? target_duty : up_sum[DUTY_W-1:0];
        end else if (down_gap > STEP) begin
            next_duty = cur_duty - STEP[DUTY_W-1:0];
        end else begin
            next_duty = target_duty;
        end
    end

endmodule

// File: rtl/pwm_profile_sequencer.sv
// Programmable N-state PWM profile engine: dwells a fixed number of periods per
// state, updates duty only at period boundaries, and drives the PWM pin itself.
module pwm_profile_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned N_STATES      = 6,
    parameter int unsigned DUTY_W        = 12,
    parameter int unsigned PWM_PERIOD    = 1200,
    parameter int unsigned DWELL_PERIODS = 1000,
    parameter int unsigned RAMP_STEP     = 4,
    parameter int unsigned IDX_W         = $clog2(N_STATES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [DUTY_W-1:0] cfg_target,
    input  logic              cfg_ramp,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty,
    output logic [IDX_W-1:0]  state,
    output logic              period_tick,
    output logic              state_done
);

    localparam int unsigned       DWELL_W    = $clog2(DWELL_PERIODS + 1);
    localparam logic [DUTY_W-1:0] PWM_LAST   = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_PERIODS - 1);
    localparam logic [IDX_W-1:0]  STATE_LAST = IDX_W'(N_STATES - 1);

    logic [DUTY_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [IDX_W-1:0]   state_q, state_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;

    logic [DUTY_W-1:0]  target_q [N_STATES];
    logic [DUTY_W-1:0]  target_d [N_STATES];
    pwm_mode_t          mode_q   [N_STATES];
    pwm_mode_t          mode_d   [N_STATES];
    pwm_entry_t         def_tbl  [N_STATES];

    logic               tick;
    logic               last_dwell;
    logic [IDX_W-1:0]   state_nxt;
    logic [DUTY_W-1:0]  stepped_duty;

    always_comb begin
        for (int i = 0; i < N_STATES; i++) begin
            def_tbl[i] = default_entry(i, PWM_PERIOD);
        end
    end

    assign tick       = en && (pwm_cnt_q == PWM_LAST);
    assign last_dwell = (dwell_cnt_q == DWELL_LAST);
    assign state_nxt  = !last_dwell ? state_q :
                        (state_q == STATE_LAST) ? '0 : state_q + IDX_W'(1);

    // Duty for the coming period is taken from the entry of the state being entered.
    pwm_duty_stepper #(
        .DUTY_W    (DUTY_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_stepper (
        .cur_duty    (duty_q),
        .target_duty (target_q[state_nxt]),
        .mode        (mode_q[state_nxt]),
        .next_duty   (stepped_duty)
    );

    always_comb begin
        pwm_cnt_d   = '0;
        dwell_cnt_d = '0;
        state_d     = '0;
        duty_d      = '0;
        if (en) begin
            pwm_cnt_d   = tick ? '0 : pwm_cnt_q + DUTY_W'(1);
            dwell_cnt_d = dwell_cnt_q;
            state_d     = state_q;
            duty_d      = duty_q;
            if (tick) begin
                dwell_cnt_d = last_dwell ? '0 : dwell_cnt_q + DWELL_W'(1);
                state_d     = state_nxt;
                duty_d      = stepped_duty;
            end
        end
    end

    always_comb begin
        target_d = target_q;
        mode_d   = mode_q;
        if (cfg_we && (32'(cfg_idx) < N_STATES)) begin
            target_d[cfg_idx] = cfg_target;
            mode_d[cfg_idx]   = cfg_ramp ? PWM_RAMP : PWM_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q   <= '0;
            dwell_cnt_q <= '0;
            state_q     <= '0;
            duty_q      <= '0;
            // NOTE: the table is reset on purpose; reset must restore the default profile.
            for (int i = 0; i < N_STATES; i++) begin
                target_q[i] <= DUTY_W'(def_tbl[i].target);
                mode_q[i]   <= def_tbl[i].mode;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            pwm_cnt_q   <= pwm_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            state_q     <= state_d;
            duty_q      <= duty_d;
            target_q    <= target_d;
            mode_q      <= mode_d;
        end
    end

    assign pwm_out     = en && (pwm_cnt_q < duty_q);
    assign duty        = duty_q;
    assign state       = state_q;
    assign period_tick = tick;
    assign state_done  = tick && last_dwell;

endmodule

// File: tb/tb_pwm_profile_sequencer.sv
// Directed and randomized checks of the PWM profile sequencer against a
// period-level reference model built from clock counts since enable.
module tb_pwm_profile_sequencer;

    localparam int P = 10;
    localparam int D = 2;
    localparam int S = 3;
    localparam int N = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [11:0] cfg_target = '0;
    logic        cfg_ramp = 1'b0;
    logic        pwm_out;
    logic [11:0] duty;
    logic [2:0]  state;
    logic        period_tick;
    logic        state_done;

    pwm_profile_sequencer #(
        .N_STATES      (N),
        .DUTY_W        (12),
        .PWM_PERIOD    (P),
        .DWELL_PERIODS (D),
        .RAMP_STEP     (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_target  (cfg_target),
        .cfg_ramp    (cfg_ramp),
        .pwm_out     (pwm_out),
        .duty        (duty),
        .state       (state),
        .period_tick (period_tick),
        .state_done  (state_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: clocks elapsed since enable/reset, applied duty, table.
    int m_cyc   = 0;
    int m_duty  = 0;
    int m_tgt  [N];
    bit m_ramp [N];
    bit m_valid = 1'b0;
    bit last_pwm;
    bit last_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ramp_to(input int cur, input int tgt, input bit ramp);
        if (!ramp) return tgt;
        if (tgt > cur) return (cur + S > tgt) ? tgt : cur + S;
        return (cur - S < tgt) ? tgt : cur - S;
    endfunction

    task automatic model_defaults();
        m_tgt  = '{0, 0, P, P, P, 0};
        m_ramp = '{0, 0, 1, 0, 0, 1};
    endtask

    task automatic model_edge(input bit r, input bit e, input bit we,
                              input int idx, input int tgt, input bit rmp);
        int s_new;
        if (r) begin
            m_cyc  = 0;
            m_duty = 0;
            model_defaults();
            return;
        end
        if (!e) begin
            m_cyc  = 0;
            m_duty = 0;
        end else begin
            if (m_cyc % P == P - 1) begin
                s_new  = ((m_cyc / P + 1) / D) % N;
                m_duty = ramp_to(m_duty, m_tgt[s_new], m_ramp[s_new]);
            end
            m_cyc++;
        end
        if (we && idx < N) begin
            m_tgt[idx]  = tgt;
            m_ramp[idx] = rmp;
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic we,
                         input logic [2:0] idx, input logic [11:0] tgt, input logic rmp);
        int  pos;
        int  pidx;
        bit  exp_tick;
        rst = r; en = e; cfg_we = we; cfg_idx = idx; cfg_target = tgt; cfg_ramp = rmp;
        #1;
        if (m_valid) begin
            pos      = m_cyc % P;
            pidx     = m_cyc / P;
            exp_tick = e && (pos == P - 1);
            check("state", 32'(state), 32'((pidx / D) % N));
            check("duty", 32'(duty), 32'(m_duty));
            check("pwm_out", 32'(pwm_out), 32'(e && (pos < m_duty)));
            check("period_tick", 32'(period_tick), 32'(exp_tick));
            check("state_done", 32'(state_done), 32'(exp_tick && (pidx % D == D - 1)));
        end
        last_pwm  = pwm_out;
        last_done = state_done;
        @(posedge clk);
        model_edge(r, e, we, int'(idx), int'(tgt), rmp);
        if (r) m_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 3'd0, 12'd0, 1'b0);
    endtask

    task automatic run_periods(input string tag, input int exp_q[$], output int done_cnt);
        int highs;
        done_cnt = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("%s_duty_p%0d", tag, k), 32'(duty), 32'(exp_q[k]));
            highs = 0;
            for (int j = 0; j < P; j++) begin
                cycle(1'b0, 1'b1, 1'b0, 3'd0, 12'd0, 1'b0);
                highs += int'(last_pwm);
                done_cnt += int'(last_done);
            end
            check($sformatf("%s_highs_p%0d", tag, k), 32'(highs),
                  32'((exp_q[k] > P) ? P : exp_q[k]));
        end
    endtask

    task automatic do_reset(input logic e);
        cycle(1'b1, e, 1'b0, 3'd0, 12'd0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp1[$];
        int expq[$];
        int dn;
        bit en_r;
        bit r_r;
        bit we_r;
        logic [2:0]  ix_r;
        logic [11:0] tg_r;
        bit rm_r;

        model_defaults();
        exp1 = '{0, 0, 0, 0, 3, 6, 10, 10, 10, 10, 7, 4, 0};
        @(negedge clk);

        // Reset state
        do_reset(1'b0);
        do_reset(1'b0);
        check("rst_duty", 32'(duty), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_tick", 32'(period_tick), 32'd0);
        check("rst_done", 32'(state_done), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 3'd0, 12'd0, 1'b0);

        // Default profile, including wrap back to state 0
        run_periods("dflt", exp1, dn);
        check("dflt_done_pulses", 32'(dn), 32'd6);

        // Ramp saturation up and down
        do_reset(1'b0);
        for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, 1'b1, 3'(i), 12'd10, 1'b1);
        expq = '{0, 3, 6, 9, 10};
        run_periods("sat_up", expq, dn);
        check("sat_top", 32'(duty), 32'd10);
        for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, 1'b1, 3'(i), 12'd0, 1'b1);
        idle(P - N);
        expq = '{7, 4, 1, 0, 0};
        run_periods("sat_dn", expq, dn);

        // Enable drop in state 3, then restart from state 0
        do_reset(1'b0);
        idle(65);
        check("pre_drop_state", 32'(state), 32'd3);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 12'd0, 1'b0);
        check("drop_pwm", 32'(pwm_out), 32'd0);
        check("drop_duty", 32'(duty), 32'd0);
        check("drop_state", 32'(state), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 3'd0, 12'd0, 1'b0);
        run_periods("reen", exp1, dn);

        // Write landing on the tick that enters state 1; out-of-range write ignored
        do_reset(1'b1);
        idle(5);
        cycle(1'b0, 1'b1, 1'b1, 3'd7, 12'd4095, 1'b1);
        idle(13);
        check("wr_on_tick_is_tick", 32'(period_tick), 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 3'd1, 12'd5, 1'b0);
        expq = '{0, 5, 8, 10, 10, 10, 10, 10, 7, 4, 0, 0, 5, 5};
        run_periods("cfgwr", expq, dn);

        // Boundary duties: full period, near/at max code, zero
        do_reset(1'b0);
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 12'd4095, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 3'd1, 12'd4094, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 3'd2, 12'd4095, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 3'd3, 12'd0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 3'd4, 12'd10, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 3'd5, 12'd0, 1'b0);
        expq = '{0, 4095, 4094, 4094, 4095, 4095, 4092, 4089, 10, 10, 0, 0, 4095};
        run_periods("bound", expq, dn);

        // Reset in the middle of a reprogrammed state-2 ramp restores defaults
        do_reset(1'b0);
        cycle(1'b0, 1'b0, 1'b1, 3'd2, 12'd7, 1'b1);
        idle(45);
        check("mid_ramp_state", 32'(state), 32'd2);
        check("mid_ramp_duty", 32'(duty), 32'd3);
        do_reset(1'b1);
        check("rst_mid_duty", 32'(duty), 32'd0);
        check("rst_mid_state", 32'(state), 32'd0);
        check("rst_mid_pwm", 32'(pwm_out), 32'd0);
        run_periods("after_rst", exp1, dn);

        // Randomized traffic against the model
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (en_r) en_r = ($urandom_range(0, 199) != 0);
            else      en_r = ($urandom_range(0, 9) == 0);
            r_r  = ($urandom_range(0, 599) == 0);
            we_r = ($urandom_range(0, 7) == 0);
            ix_r = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0:       tg_r = 12'd0;
                1:       tg_r = 12'd10;
                2:       tg_r = 12'hFFF;
                3:       tg_r = 12'($urandom_range(0, 15));
                default: tg_r = 12'($urandom);
            endcase
            rm_r = 1'($urandom_range(0, 1));
            cycle(r_r, en_r, we_r, ix_r, tg_r, rm_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
